// File: rtl/cla_alu_seq_pkg.sv
// Shared op codes, FSM state encodings and small decode helpers for the
// handshaked CLA ALU.
package cla_alu_seq_pkg;

    // Operation codes presented on the op port
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;

    // Control FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Codes 6 and 7 are reserved and produce err=1
    function automatic logic op_reserved(input logic [2:0] code);
        return (code > OP_MUL);
    endfunction

    // Add and subtract share the lookahead adder; subtract inverts B and sets carry-in
    function automatic logic op_is_sub(input logic [2:0] code);
        return (code == OP_SUB);
    endfunction

endpackage

// File: rtl/cla_alu_seq_adder.sv
// Parametrised carry-lookahead adder built from GROUP-bit lookahead blocks
// joined by a group-level carry lookahead. The top group may be shorter than
// GROUP when WIDTH is not a multiple of it. c_msb_in is the carry into the
// most significant bit, so signed overflow is cout ^ c_msb_in.
module cla_adder
    import cla_alu_seq_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    localparam int NG = (WIDTH + GROUP - 1) / GROUP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;

    assign g = a & b;
    assign p = a ^ b;

    // Group-level lookahead: carry into each group from group generate/propagate
    always_comb begin
        grp_c    = '0;
        grp_c[0] = cin;
        for (int unsigned k = 0; k < NG; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    assign cout = grp_c[NG];

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = k * GROUP;
        localparam int HI = ((k + 1) * GROUP > WIDTH) ? (WIDTH - 1) : ((k + 1) * GROUP - 1);
        localparam int N  = HI - LO + 1;

        // pre_g[i]/pre_p[i] cover bits LO..LO+i-1 of this group; independent of carry-in
        logic [N:0]   pre_g;
        logic [N:0]   pre_p;
        logic [N-1:0] c;

        // Prefix generate/propagate inside the group
        always_comb begin
            pre_g    = '0;
            pre_p    = '0;
            pre_p[0] = 1'b1;
            for (int unsigned i = 0; i < N; i++) begin
                pre_g[i+1] = g[LO+i] | (p[LO+i] & pre_g[i]);
                pre_p[i+1] = p[LO+i] & pre_p[i];
            end
        end

        // Every bit carry comes straight from the group carry-in
        assign c             = pre_g[N-1:0] | (pre_p[N-1:0] & {N{grp_c[k]}});
        assign sum[HI:LO]    = p[HI:LO] ^ c;
        assign grp_g[k]      = pre_g[N];
        assign grp_p[k]      = pre_p[N];

        if (k == NG - 1) begin : g_msb
            assign c_msb_in = c[N-1];
        end
    end

endmodule

// File: rtl/cla_alu_seq.sv
// Handshaked, parametrised ALU: ADD/SUB through a carry-lookahead adder,
// bitwise logic ops, and a multi-cycle radix-2 signed multiply whose
// accumulator is a 2*WIDTH lookahead adder. One operation in flight.
module cla_alu_seq
    import cla_alu_seq_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             v,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] s);
        return s[WIDTH-1] ? (~s + WIDTH'(1)) : s;
    endfunction

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg;

    logic             accept;
    logic             mul_last;

    assign accept   = in_valid & in_ready;
    assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));

    // ---------------- single-cycle result path ----------------
    logic             sub_op;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_cmsb;

    assign sub_op = op_is_sub(op);
    assign add_b  = sub_op ? ~y : y;

    cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) u_res_add (
        .a        (x),
        .b        (add_b),
        .cin      (sub_op),
        .sum      (add_sum),
        .cout     (add_cout),
        .c_msb_in (add_cmsb)
    );

    logic [WIDTH-1:0] alu_z;
    logic             alu_v;
    logic             alu_err;

    // Result for every op that completes on the accept edge
    always_comb begin
        alu_z   = '0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_z = add_sum;
                alu_v = add_cout ^ add_cmsb;
            end
            OP_AND: alu_z = x & y;
            OP_OR:  alu_z = x | y;
            OP_XOR: alu_z = x ^ y;
            OP_MUL: alu_z = '0;
            default: alu_err = op_reserved(op);
        endcase
    end

    // ---------------- multiply accumulator ----------------
    logic [W2-1:0]  pp;
    logic [W2-1:0]  mul_sum;
    logic           acc_cout_unused;
    logic           acc_cmsb_unused;
    logic [W2-1:0]  prod;
    logic [WIDTH:0] prod_hi;
    logic           mul_v;

    assign pp = mplier[0] ? mcand : '0;

    cla_adder #(.WIDTH(W2), .GROUP(GROUP)) u_acc_add (
        .a        (acc),
        .b        (pp),
        .cin      (1'b0),
        .sum      (mul_sum),
        .cout     (acc_cout_unused),
        .c_msb_in (acc_cmsb_unused)
    );

    // mul_sum already includes the last partial product when mul_last is high,
    // so the signed product is formed and registered on that same edge.
    assign prod    = neg ? (~mul_sum + W2'(1)) : mul_sum;
    assign prod_hi = prod[W2-1:WIDTH-1];
    assign mul_v   = ~((&prod_hi) | ~(|prod_hi));

    // ---------------- control ----------------
    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; in_ready is held low through reset and high only in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == S_IDLE);
        end
    end

    // Multiply operand magnitudes, shifting multiplicand/multiplier and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
        end else if (accept && op == OP_MUL) begin
            acc    <= '0;
            mcand  <= W2'(mag(x));
            mplier <= mag(y);
            neg    <= x[WIDTH-1] ^ y[WIDTH-1];
            cnt    <= '0;
        end else if (state == S_MUL) begin
            acc    <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Registered result outputs; held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            v         <= 1'b0;
            err       <= 1'b0;
        end else if (accept && op != OP_MUL) begin
            out_valid <= 1'b1;
            z         <= alu_z;
            v         <= alu_v;
            err       <= alu_err;
        end else if (mul_last) begin
            out_valid <= 1'b1;
            z         <= prod[WIDTH-1:0];
            v         <= mul_v;
            err       <= 1'b0;
        end else if (state == S_DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_alu_seq.sv
// Directed and randomised bench for cla_alu_seq at WIDTH=18. Expected results
// come from a wide-integer reference model and are queued per issued op.
module tb_cla_alu_seq;

    localparam int W = 18;
    localparam longint MINV = -(longint'(1) << (W - 1));
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] z;
    logic         v;
    logic         err;

    typedef struct {
        logic [W-1:0] z;
        logic         v;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat    = 0;

    cla_alu_seq #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .v         (v),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
        exp_t   e;
        longint sa;
        longint sb2;
        longint r;
        sa    = longint'($signed(a));
        sb2   = longint'($signed(b));
        r     = 0;
        e.z   = '0;
        e.v   = 1'b0;
        e.err = 1'b0;
        e.lat = 1;
        case (o)
            3'd0: begin r = sa + sb2; e.z = r[W-1:0]; e.v = (r < MINV) || (r > MAXV); end
            3'd1: begin r = sa - sb2; e.z = r[W-1:0]; e.v = (r < MINV) || (r > MAXV); end
            3'd2: e.z = a & b;
            3'd3: e.z = a | b;
            3'd4: e.z = a ^ b;
            3'd5: begin r = sa * sb2; e.z = r[W-1:0]; e.v = (r < MINV) || (r > MAXV); e.lat = W + 1; end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
        int n;
        sb.push_back(model(a, b, o));
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        x        = a;
        y        = b;
        op       = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
    endtask

    task automatic recv(input string tag);
        exp_t e;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_z"},   64'(z),   64'(e.z));
            check({tag, "_v"},   64'(v),   64'(e.v));
            check({tag, "_err"}, 64'(err), 64'(e.err));
            check({tag, "_lat"}, 64'(lat), 64'(e.lat));
        end
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"},   64'(in_ready),  64'd1);
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
        send(a, b, o);
        recv(tag);
        take(tag);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   ro;
        exp_t         bp;

        // Reset state
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_z",         64'(z),         64'd0);
        check("rst_v",         64'(v),         64'd0);
        check("rst_err",       64'(err),       64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Adder boundaries
        run("add_ovf",   18'sd131071,  18'sd1,      3'd0);
        run("sub_neg",  -18'sd5,       18'sd3,      3'd1);
        run("sub_ovf",  -18'sd131072,  18'sd1,      3'd1);
        run("add_wrap", -18'sd131072, -18'sd1,      3'd0);

        // Multiply cases
        run("mul_mix",   18'sd300,    -18'sd400,    3'd5);
        run("mul_ovf",   18'sd1000,    18'sd1000,   3'd5);
        run("mul_min_n1", -18'sd131072, -18'sd1,    3'd5);
        run("mul_min_p1", -18'sd131072,  18'sd1,    3'd5);
        run("mul_zero",  18'sd0,      -18'sd999,    3'd5);

        // Reserved ops, then ADD clears err
        run("rsv6", 18'sd12, 18'sd34, 3'd6);
        run("rsv7", 18'sd12, 18'sd34, 3'd7);
        run("add_after_rsv", 18'sd12, 18'sd34, 3'd0);

        // Sign-quadrant corners for every defined op
        for (int unsigned q = 0; q < 4; q++) begin
            ra = q[0] ? -18'sd999 : 18'sd999;
            rb = q[1] ? -18'sd987 : 18'sd987;
            for (int unsigned o = 0; o < 6; o++) begin
                run("quad", ra, rb, 3'(o));
            end
        end

        // Random sweep over +/-0..999 and all op codes
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 999));
            rb = W'($urandom_range(0, 999));
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            ro = 3'($urandom_range(0, 7));
            run("rand", ra, rb, ro);
        end

        // Backpressure: result held, new requests ignored
        bp = model(18'sd1234, -18'sd77, 3'd0);
        out_ready = 1'b0;
        send(18'sd1234, -18'sd77, 3'd0);
        recv("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x  = 18'sd5;
            y  = 18'sd6;
            op = 3'd1;
            @(posedge clk);
            #1;
            check("bp_hold_z",        64'(z),         64'(bp.z));
            check("bp_hold_v",        64'(v),         64'(bp.v));
            check("bp_hold_valid",    64'(out_valid), 64'd1);
            check("bp_hold_in_ready", 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        take("bp");
        @(posedge clk);
        #1;
        check("bp_no_ghost", 64'(out_valid), 64'd0);

        // Reset in the middle of a multiply discards it
        run("pre_rst", 18'sd100, 18'sd23, 3'd0);
        send(18'sd300, -18'sd400, 3'd5);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_z",         64'(z),         64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(out_valid), 64'd0);
        run("post_rst_add", 18'sd2, 18'sd3, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
